// File: rtl/change_dispenser.sv
// Coin payout sequencer: pays a refund amount as greedy 50/10/5 solenoid pulses,
// spaced by a fixed gap, while tracking per-denomination hopper inventory.
module change_dispenser #(
    parameter int unsigned GAP_CYC = 2,
    parameter logic [7:0]  INIT_50 = 8'd4,
    parameter logic [7:0]  INIT_10 = 8'd10,
    parameter logic [7:0]  INIT_5  = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refund_valid,
    input  logic [6:0] refund_amount,
    input  logic       restock,
    output logic       dispense_50,
    output logic       dispense_10,
    output logic       dispense_5,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [6:0] remaining,
    output logic [7:0] inv_50,
    output logic [7:0] inv_10,
    output logic [7:0] inv_5
);

    localparam int unsigned GapW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {StIdle, StPick, StDrop, StGap, StFinish} state_e;

    state_e            state_q, state_d;
    logic [6:0]        rem_q, rem_d;
    logic [7:0]        inv50_q, inv50_d;
    logic [7:0]        inv10_q, inv10_d;
    logic [7:0]        inv5_q, inv5_d;
    logic [2:0]        sel_q, sel_d;   // one-hot {50, 10, 5} chosen in PICK
    logic [GapW-1:0]   gap_q, gap_d;
    logic              short_q, short_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= 7'd0;
            inv50_q <= INIT_50;
            inv10_q <= INIT_10;
            inv5_q  <= INIT_5;
            sel_q   <= 3'b000;
            gap_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            inv50_q <= inv50_d;
            inv10_q <= inv10_d;
            inv5_q  <= inv5_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        inv50_d = inv50_q;
        inv10_d = inv10_q;
        inv5_d  = inv5_q;
        sel_d   = sel_q;
        gap_d   = gap_q;
        short_d = short_q;
        unique case (state_q)
            StIdle: begin
                if (refund_valid) begin
                    rem_d   = refund_amount;
                    short_d = 1'b0;
                    state_d = StPick;
                end else if (restock) begin
                    inv50_d = INIT_50;
                    inv10_d = INIT_10;
                    inv5_d  = INIT_5;
                end
            end
            StPick: begin
                if (rem_q == 7'd0) begin
                    short_d = 1'b0;
                    state_d = StFinish;
                end else if (rem_q >= 7'd50 && inv50_q != 8'd0) begin
                    sel_d   = 3'b100;
                    state_d = StDrop;
                end else if (rem_q >= 7'd10 && inv10_q != 8'd0) begin
                    sel_d   = 3'b010;
                    state_d = StDrop;
                end else if (rem_q >= 7'd5 && inv5_q != 8'd0) begin
                    sel_d   = 3'b001;
                    state_d = StDrop;
                end else begin
                    short_d = 1'b1;
                    state_d = StFinish;
                end
            end
            StDrop: begin
                if (sel_q[2]) begin
                    rem_d   = rem_q - 7'd50;
                    inv50_d = inv50_q - 8'd1;
                end else if (sel_q[1]) begin
                    rem_d   = rem_q - 7'd10;
                    inv10_d = inv10_q - 8'd1;
                end else if (sel_q[0]) begin
                    rem_d   = rem_q - 7'd5;
                    inv5_d  = inv5_q - 8'd1;
                end
                gap_d   = GapW'(GAP_CYC);
                state_d = StGap;
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    state_d = StPick;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign dispense_50 = (state_q == StDrop) && sel_q[2];
    assign dispense_10 = (state_q == StDrop) && sel_q[1];
    assign dispense_5  = (state_q == StDrop) && sel_q[0];
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StFinish);
    assign short       = short_q;
    assign remaining   = rem_q;
    assign inv_50      = inv50_q;
    assign inv_10      = inv10_q;
    assign inv_5       = inv5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances with different hopper loads,
// cycle-exact checks of dispense pulses, busy/done/short/remaining and inventories.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic [2:0] rv, rs;
    logic [6:0] amt [3];
    logic [2:0] d50, d10, d5, bsy, dn, sht;
    logic [6:0] rem [3];
    logic [7:0] i50 [3];
    logic [7:0] i10 [3];
    logic [7:0] i5  [3];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    change_dispenser u0 (
        .clk(clk), .rst(rst), .refund_valid(rv[0]), .refund_amount(amt[0]), .restock(rs[0]),
        .dispense_50(d50[0]), .dispense_10(d10[0]), .dispense_5(d5[0]), .busy(bsy[0]),
        .done(dn[0]), .short(sht[0]), .remaining(rem[0]),
        .inv_50(i50[0]), .inv_10(i10[0]), .inv_5(i5[0])
    );

    change_dispenser #(.INIT_50(8'd0)) u1 (
        .clk(clk), .rst(rst), .refund_valid(rv[1]), .refund_amount(amt[1]), .restock(rs[1]),
        .dispense_50(d50[1]), .dispense_10(d10[1]), .dispense_5(d5[1]), .busy(bsy[1]),
        .done(dn[1]), .short(sht[1]), .remaining(rem[1]),
        .inv_50(i50[1]), .inv_10(i10[1]), .inv_5(i5[1])
    );

    change_dispenser #(.INIT_10(8'd3), .INIT_5(8'd0)) u2 (
        .clk(clk), .rst(rst), .refund_valid(rv[2]), .refund_amount(amt[2]), .restock(rs[2]),
        .dispense_50(d50[2]), .dispense_10(d10[2]), .dispense_5(d5[2]), .busy(bsy[2]),
        .done(dn[2]), .short(sht[2]), .remaining(rem[2]),
        .inv_50(i50[2]), .inv_10(i10[2]), .inv_5(i5[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inv(input int k, input logic [7:0] e50, input logic [7:0] e10,
                           input logic [7:0] e5);
        chk("inv_50", i50[k], e50);
        chk("inv_10", i10[k], e10);
        chk("inv_5", i5[k], e5);
    endtask

    // Issues a request on instance k and checks every cycle through one past done.
    // With GAP_CYC=2 pulse j lands in cycle 2+4j and done in cycle 2+4n.
    task automatic payout(input int k, input logic [6:0] amount, input int n50, input int n10,
                          input int n5, input logic exp_short, input logic [6:0] exp_rem,
                          input int inj, input logic rs_start);
        int n;
        int last;
        int j;
        logic [2:0] expd;
        n    = n50 + n10 + n5;
        last = 2 + 4 * n;
        amt[k] = amount;
        rv[k]  = 1'b1;
        rs[k]  = rs_start;
        @(posedge clk); #1;
        rv[k] = 1'b0;
        rs[k] = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            expd = 3'b000;
            if (c >= 2 && c < last && ((c - 2) % 4) == 0) begin
                j = (c - 2) / 4;
                if (j < n50)            expd = 3'b100;
                else if (j < n50 + n10) expd = 3'b010;
                else                    expd = 3'b001;
            end
            chk("dispense", {d50[k], d10[k], d5[k]}, expd);
            chk("busy", bsy[k], c <= last);
            chk("done", dn[k], c == last);
            if (c >= last) begin
                chk("short", sht[k], exp_short);
                chk("remaining", rem[k], exp_rem);
            end
            if (c == inj) begin
                rv[k]  = 1'b1;
                rs[k]  = 1'b1;
                amt[k] = 7'd50;
            end else begin
                rv[k] = 1'b0;
                rs[k] = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        rv  = 3'b000;
        rs  = 3'b000;
        for (int k = 0; k < 3; k++) amt[k] = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dispense", {d50[0], d10[0], d5[0]}, 3'b000);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_done", dn[0], 1'b0);
        chk("rst_short", sht[0], 1'b0);
        chk("rst_remaining", rem[0], 7'd0);
        chk_inv(0, 8'd4, 8'd10, 8'd10);
        chk_inv(1, 8'd0, 8'd10, 8'd10);
        chk_inv(2, 8'd4, 8'd3, 8'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 65 = 50 + 10 + 5
        payout(0, 7'd65, 1, 1, 1, 1'b0, 7'd0, 0, 1'b0);
        chk_inv(0, 8'd3, 8'd9, 8'd9);

        // Request and restock injected in GAP must be ignored
        payout(0, 7'd30, 0, 3, 0, 1'b0, 7'd0, 3, 1'b0);
        chk_inv(0, 8'd3, 8'd6, 8'd9);

        payout(0, 7'd0, 0, 0, 0, 1'b0, 7'd0, 0, 1'b0);
        payout(0, 7'd7, 0, 0, 1, 1'b1, 7'd2, 0, 1'b0);
        chk_inv(0, 8'd3, 8'd6, 8'd8);

        // Refund and restock together: refund wins
        payout(0, 7'd5, 0, 0, 1, 1'b0, 7'd0, 0, 1'b1);
        chk_inv(0, 8'd3, 8'd6, 8'd7);

        rs[0] = 1'b1;
        @(posedge clk); #1;
        rs[0] = 1'b0;
        chk_inv(0, 8'd4, 8'd10, 8'd10);

        // 127 = 50+50+10+10+5, short by 2
        payout(0, 7'd127, 2, 2, 1, 1'b1, 7'd2, 0, 1'b0);
        chk_inv(0, 8'd2, 8'd8, 8'd9);

        // No 50s loaded: 60 paid as six 10s
        rs[1] = 1'b1;
        @(posedge clk); #1;
        rs[1] = 1'b0;
        payout(1, 7'd60, 0, 6, 0, 1'b0, 7'd0, 0, 1'b0);
        chk_inv(1, 8'd0, 8'd4, 8'd10);

        // Only three 10s and no 5s: 35 ends short with 5 owed
        payout(2, 7'd35, 0, 3, 0, 1'b1, 7'd5, 0, 1'b0);
        chk_inv(2, 8'd4, 8'd0, 8'd0);

        // Reset between DROPs
        amt[0] = 7'd65;
        rv[0]  = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_inv_50", i50[0], 8'd1);
        chk("mid_remaining", rem[0], 7'd15);
        chk("mid_busy", bsy[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_dispense", {d50[0], d10[0], d5[0]}, 3'b000);
        chk("ar_busy", bsy[0], 1'b0);
        chk("ar_done", dn[0], 1'b0);
        chk("ar_short", sht[0], 1'b0);
        chk("ar_remaining", rem[0], 7'd0);
        chk_inv(0, 8'd4, 8'd10, 8'd10);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            chk("ar_no_done", dn[0], 1'b0);
            chk("ar_no_dispense", {d50[0], d10[0], d5[0]}, 3'b000);
            @(posedge clk); #1;
        end
        payout(0, 7'd65, 1, 1, 1, 1'b0, 7'd0, 0, 1'b0);
        chk_inv(0, 8'd3, 8'd9, 8'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits directly downstream of vending_machine.
- Takes the change/refund amount that vending_machine produces on cancel or after a purchase (7-bit coin value) and pays it out one physical coin at a time.
- Drives three coin-hopper solenoid pulses (50/10/5), greedy largest-first, with a fixed gap between coins.
- Tracks per-denomination hopper inventory and flags when exact change cannot be paid.

Parameters:
- GAP_CYC, 2: idle cycles after each dispense pulse before the next selection (≥1).
- INIT_50, 4: 50-coin inventory loaded at reset and on restock.
- INIT_10, 10: 10-coin inventory loaded at reset and on restock.
- INIT_5, 10: 5-coin inventory loaded at reset and on restock.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- refund_valid  in  1  one-cycle request; sample refund_amount
- refund_amount  in  7  amount to pay out, 0..127
- restock  in  1  one-cycle pulse; reload inventories to INIT_* values
- dispense_50  out  1  one-cycle solenoid pulse, one 50 coin
- dispense_10  out  1  one-cycle solenoid pulse, one 10 coin
- dispense_5  out  1  one-cycle solenoid pulse, one 5 coin
- busy  out  1  high from the cycle after an accepted request through FINISH
- done  out  1  one-cycle pulse, payout ended
- short  out  1  valid with done; 1 = amount not fully paid
- remaining  out  7  amount still owed; holds its value after done until the next request
- inv_50, inv_10, inv_5  out  8 each  current hopper counts

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All dispense_*, busy, done and short = 0; remaining = 0.
  - inv_* = INIT_*.
  - Reset mid-payout aborts immediately. No done pulse. Coins already dispensed stay deducted only until reset reloads INIT_*.
- FSM states: IDLE, PICK, DROP, GAP, FINISH.
- IDLE:
  - busy=0.
  - refund_valid=1: load remaining ← refund_amount, go to PICK.
  - restock=1 (and refund_valid=0): inv_* ← INIT_*.
  - refund_valid and restock together: refund wins, restock ignored.
- PICK, evaluated in one cycle:
  - remaining==0: go to FINISH with short=0.
  - Otherwise choose d = the first of 50, 10, 5 with d ≤ remaining and inv_d > 0, then go to DROP.
  - No such d (including remaining < 5, or hoppers empty): go to FINISH with short=1.
- DROP:
  - dispense_d=1 for exactly this cycle.
  - At the end of the cycle: remaining ← remaining − d; inv_d ← inv_d − 1.
  - Then go to GAP, with the counter loaded to GAP_CYC.
- GAP: hold for GAP_CYC cycles with all dispense_* = 0, then go to PICK.
- FINISH: done=1 for one cycle, short valid, then go to IDLE.
- Inputs ignored while not in IDLE: refund_valid and restock.
- Output exclusivity: at most one dispense_* is high in any cycle; they never assert outside DROP.
- Per-coin period is GAP_CYC+2 cycles.
- Timing, request sampled at edge 0:
  - PICK runs in cycle 1.
  - The first dispense is in cycle 2.
  - done comes 2 cycles after the last GAP ends.
- Arithmetic:
  - remaining is 7 bits; the subtraction never underflows because d ≤ remaining is checked in PICK.
  - inv_* never decrements below 0.
- An amount that is not a multiple of 5 pays the greedy part, then ends short with remaining in 1..4.

Test Plan:
- Reset, GAP_CYC=2, refund 65 at edge 0 → dispense_50@c2, dispense_10@c6, dispense_5@c10; done@c14, short=0, remaining=0; inv = 3/9/9.
- Restock to INIT_50=0, refund 60 → six dispense_10 pulses spaced 4 cycles apart; done, short=0; inv_10=4.
- INIT_10=3, INIT_5=0, refund 35 → three dispense_10 pulses; done with short=1, remaining=5; inv_10=0.
- Refund 0 → no dispense; done 2 cycles after request, short=0. Refund 7 → one dispense_5, then done with short=1, remaining=2.
- Second refund_valid and a restock pulse issued mid-payout → both ignored; only the original amount is paid and inventories are not reloaded.
- rst asserted between two DROPs → all outputs 0 immediately, inv_* = INIT_*, no done pulse; a fresh refund afterwards pays normally.
